// File: rtl/stack_pkg.sv
// Shared types and defaults for the hardware operand stack.
// The optional sticky error flags are enabled with the STACK_ERR_EN macro.
package stack_pkg;

  localparam int unsigned StackDataW = 8;
  localparam int unsigned StackDepth = 8;

  // Occupancy counter must hold 0..depth inclusive, hence one extra bit.
  function automatic int unsigned ptr_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic push;
    logic pop;
    logic tos;
  } stack_cmd_t;

  typedef enum logic [2:0] {
    OpNone,
    OpPush,
    OpPop,
    OpTos,
    OpSwap,
    OpPushTos
  } stack_op_t;

  // Resolve simultaneous command pulses into one operation. Pop dominates
  // tos; push+pop on an empty stack degrades to a plain push.
  function automatic stack_op_t decode_op(stack_cmd_t cmd, logic empty);
    if (cmd.push && cmd.pop) return empty ? OpPush : OpSwap;
    if (cmd.pop)             return OpPop;
    if (cmd.push && cmd.tos) return empty ? OpPush : OpPushTos;
    if (cmd.push)            return OpPush;
    if (cmd.tos)             return OpTos;
    return OpNone;
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module stack_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_unit.sv
// LIFO operand stack driven by single-cycle push/pop/tos pulses; registered dout.
// Define STACK_ERR_EN to implement sticky overflow/underflow flags with err_clr.
module stack_unit
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = StackDataW,
  parameter int unsigned DEPTH  = StackDepth,
  parameter int unsigned PTR_W  = ptr_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              tos_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] dout_o,
  output logic [PTR_W-1:0]  count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [PTR_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              empty, full;
  stack_cmd_t        cmd;
  stack_op_t         op;
  logic              we;
  logic [AddrW-1:0]  waddr, top_addr;
  logic [DATA_W-1:0] top_data;
  logic              ovf_set, unf_set;

  assign empty    = (count_q == '0);
  assign full     = (count_q == PTR_W'(DEPTH));
  // On an empty stack this wraps to DEPTH-1; the read value is never used then.
  assign top_addr = AddrW'(count_q - PTR_W'(1));
  assign cmd      = '{push: push_i, pop: pop_i, tos: tos_i};
  assign op       = decode_op(cmd, empty);

  always_comb begin
    we      = 1'b0;
    waddr   = AddrW'(count_q);
    count_d = count_q;
    dout_d  = dout_q;
    unique case (op)
      OpPush: begin
        if (!full) begin
          we      = 1'b1;
          count_d = count_q + PTR_W'(1);
        end
      end
      OpPop: begin
        if (!empty) begin
          dout_d  = top_data;
          count_d = count_q - PTR_W'(1);
        end
      end
      OpTos: begin
        if (!empty) begin
          dout_d = top_data;
        end
      end
      OpSwap: begin
        dout_d = top_data;
        we     = 1'b1;
        waddr  = top_addr;
      end
      OpPushTos: begin
        dout_d = top_data;
        if (!full) begin
          we      = 1'b1;
          count_d = count_q + PTR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // A swap on a full stack frees the slot it reuses, so it is not an overflow.
  assign ovf_set = push_i & full & (op != OpSwap);
  assign unf_set = (pop_i | tos_i) & empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

`ifdef STACK_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  assign ovf_d = ovf_set | (ovf_q & ~err_clr_i);
  assign unf_d = unf_set | (unf_q & ~err_clr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
`else
  logic unused_err;
  assign unused_err  = ^{err_clr_i, ovf_set, unf_set};
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

  stack_regfile #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(AddrW)
  ) u_regfile (
    .clk_i  (clk_i),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(din_i),
    .raddr_i(top_addr),
    .rdata_o(top_data)
  );

  assign dout_o  = dout_q;
  assign count_o = count_q;
  assign empty_o = empty;
  assign full_o  = full;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: queue-based reference model, directed
// scenarios with literal expectations, then randomized command traffic.
module tb_stack_unit;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 8;
  localparam int unsigned PW = $clog2(DP) + 1;
`ifdef STACK_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push = 1'b0, pop = 1'b0, tos = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic [PW-1:0] count;
  logic          empty, full, overflow, underflow;

  always #5 clk = ~clk;

  stack_unit #(
    .DATA_W(DW),
    .DEPTH (DP),
    .PTR_W (PW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .push_i     (push),
    .pop_i      (pop),
    .tos_i      (tos),
    .din_i      (din),
    .err_clr_i  (err_clr),
    .dout_o     (dout),
    .count_o    (count),
    .empty_o    (empty),
    .full_o     (full),
    .overflow_o (overflow),
    .underflow_o(underflow)
  );

  // Reference model: the stack is a queue whose last element is the top.
  logic [DW-1:0] stk[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_ovf = 1'b0, m_unf = 1'b0;
  bit            chk_en = 1'b0;
  int            n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit pu, input bit po, input bit to, input logic [DW-1:0] d,
                            input bit clr);
    bit e, f, oset, uset;
    e    = (stk.size() == 0);
    f    = (stk.size() == DP);
    uset = (po || to) && e;
    oset = pu && f && !(po && !e);
    if (pu && po && !e) begin
      m_dout = stk[stk.size()-1];
      stk[stk.size()-1] = d;
    end else begin
      if (po && !e)      m_dout = stk.pop_back();
      else if (to && !e) m_dout = stk[stk.size()-1];
      if (pu && !f) stk.push_back(d);
    end
    m_ovf = ErrEn && (oset || (m_ovf && !clr));
    m_unf = ErrEn && (uset || (m_unf && !clr));
  endtask

  task automatic model_reset();
    stk.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout", 32'(dout), 32'(m_dout));
      chk("count", 32'(count), 32'(stk.size()));
      chk("empty", 32'(empty), 32'(stk.size() == 0));
      chk("full", 32'(full), 32'(stk.size() == DP));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
    end
  end

  // Drive one cycle of commands; returns 1 time unit after the sampling edge.
  task automatic step(input bit pu, input bit po, input bit to, input logic [DW-1:0] d,
                      input bit clr);
    push = pu; pop = po; tos = to; din = d; err_clr = clr;
    @(posedge clk);
    model_step(pu, po, to, d, clr);
    #1;
    push = 0; pop = 0; tos = 0; err_clr = 0;
  endtask

  task automatic do_push(input logic [DW-1:0] d); step(1, 0, 0, d, 0); endtask
  task automatic do_pop();                        step(0, 1, 0, '0, 0); endtask
  task automatic do_tos();                        step(0, 0, 1, '0, 0); endtask

  initial begin
    #3;
    chk("rst count", 32'(count), 0);
    chk("rst dout", 32'(dout), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst full", 32'(full), 0);
    chk("rst ovf", 32'(overflow), 0);
    chk("rst unf", 32'(underflow), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Pop from empty after reset
    do_pop();
    chk("empty pop dout", 32'(dout), 32'h00);
    chk("empty pop count", 32'(count), 0);
    chk("empty pop unf", 32'(underflow), 32'(ErrEn));
    step(0, 0, 0, '0, 1);
    chk("err_clr unf", 32'(underflow), 0);

    // Basic push/pop/tos
    do_push(8'h11); do_push(8'h22); do_push(8'h33);
    chk("3 push count", 32'(count), 3);
    do_pop();
    chk("pop dout", 32'(dout), 32'h33);
    chk("pop count", 32'(count), 2);
    do_tos();
    chk("tos dout", 32'(dout), 32'h22);
    chk("tos count", 32'(count), 2);
    do_pop(); do_pop();

    // Fill, overflow, pop
    for (int i = 1; i <= 8; i++) do_push(8'(i));
    chk("fill full", 32'(full), 1);
    chk("fill count", 32'(count), 8);
    do_push(8'h99);
    chk("ovf count", 32'(count), 8);
    chk("ovf flag", 32'(overflow), 32'(ErrEn));
    do_pop();
    chk("ovf pop dout", 32'(dout), 32'h08);
    step(0, 0, 0, '0, 1);
    chk("ovf clr", 32'(overflow), 0);
    for (int i = 0; i < 7; i++) do_pop();

    // Swap via push+pop
    do_push(8'h05); do_push(8'h07);
    step(1, 1, 0, 8'h0A, 0);
    chk("swap dout", 32'(dout), 32'h07);
    chk("swap count", 32'(count), 2);
    do_pop();
    chk("swap pop dout", 32'(dout), 32'h0A);
    do_pop();

    // Controller ADD sequence
    do_push(8'h03); do_push(8'h04);
    do_pop();
    chk("add pop1", 32'(dout), 32'h04);
    do_pop();
    chk("add pop2", 32'(dout), 32'h03);
    do_push(8'h07);
    chk("add count", 32'(count), 1);
    do_tos();
    chk("add top", 32'(dout), 32'h07);
    do_pop();

    // Randomized traffic, alternating push-heavy and pop-heavy phases
    for (int c = 0; c < 1500; c++) begin
      int pu_w;
      pu_w = ((c / 60) % 2 == 0) ? 70 : 30;
      step($urandom_range(0, 99) < pu_w, $urandom_range(0, 99) < (100 - pu_w),
           $urandom_range(0, 99) < 25, 8'($urandom), $urandom_range(0, 99) < 5);
    end
    step(0, 0, 0, '0, 1);

    // Async reset in the middle of a push burst
    while (count != 0) do_pop();
    for (int i = 0; i < 5; i++) do_push(8'(8'h40 + i));
    do_tos();
    chk("pre-rst count", 32'(count), 5);
    push = 1; din = 8'hEE;
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async count", 32'(count), 0);
    chk("async empty", 32'(empty), 1);
    chk("async dout", 32'(dout), 0);
    push = 0;
    model_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    do_push(8'h5A); do_tos();
    chk("post-rst dout", 32'(dout), 32'h5A);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware LIFO operand stack for the multi-cycle stack processor; sits directly downstream of the controller FSM.
- Executes its single-cycle push/pop/tos command pulses.
- Supplies the popped or peeked top-of-stack value on a registered output, which the datapath latches into A/B one cycle later.
- Push data comes from the datapath mux (ALU result or memory read data), selected upstream by Stack_sel.

Parameters:
DATA_W, 8, width of each stack entry and of din/dout
DEPTH, 8, number of entries (power of two, >=2)
PTR_W, $clog2(DEPTH)+1, width of the stack pointer / occupancy count (holds 0..DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
push  input  1  write din as the new top; single-cycle pulse from controller
pop  input  1  remove top entry and register it on dout
tos  input  1  register top entry on dout without removing it
din  input  DATA_W  data to push
dout  output  DATA_W  registered top-of-stack read value
count  output  PTR_W  current occupancy 0..DEPTH
empty  output  1  count==0, combinational from count
full  output  1  count==DEPTH, combinational from count
overflow  output  1  sticky: push attempted while full (STACK_ERR_EN only)
underflow  output  1  sticky: pop/tos attempted while empty (STACK_ERR_EN only)
err_clr  input  1  synchronous clear of overflow/underflow (STACK_ERR_EN only)

Behaviour:
- Reset (rst=0, async): count=0, dout=0, overflow=0, underflow=0. Memory contents are not reset and are don't-care.
- Storage: mem[0..DEPTH-1]. The top entry is mem[count-1]. The pointer is the occupancy count; no wrap-around.
- Latency: dout updates on the clock edge that samples pop/tos, so it is valid in the next cycle (controller pop@ST1 -> en_A@ST2). dout holds its value until the next successful pop/tos.
- Push, not full: mem[count] <= din; count <= count+1; dout unchanged.
- Push, full: no write; count unchanged; overflow <= 1.
- Pop, not empty: dout <= mem[count-1]; count <= count-1.
- Pop, empty: dout and count unchanged; underflow <= 1.
- Tos, not empty: dout <= mem[count-1]; count unchanged.
- Tos, empty: dout unchanged; underflow <= 1.
- Push+pop same cycle, not empty: swap. dout <= mem[count-1]; mem[count-1] <= din; count unchanged.
- Push+pop same cycle, empty: treated as push only; underflow <= 1.
- Pop+tos same cycle: pop dominates; tos is ignored.
- Push+tos same cycle, not empty: mem[count] <= din (if not full); dout <= old top mem[count-1]; count increments if not full.
- err_clr: clears both sticky flags. A new error in the same cycle wins (flag set).
- No FSM beyond the count register. All state updates are synchronous except reset. A reset asserted mid-operation aborts any write in flight.

Optional Feature:
- Macro: STACK_ERR_EN.
- Defined: overflow/underflow sticky registers and err_clr are implemented as described above.
- Undefined: overflow and underflow are tied to 0 and err_clr is ignored. The guard behaviour is unchanged: push when full and pop/tos when empty remain no-ops.

Decomposition:
- Package stack_pkg: DATA_W/DEPTH defaults, PTR_W derivation function, and a typedef for the stack command encoding {push,pop,tos}.
- One sub-module: stack_regfile (DEPTH x DATA_W, one synchronous write port, one asynchronous read port at address count-1). The pointer, flags and dout register stay in stack_unit.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 -> count=3; pop -> next cycle dout=0x33, count=2; tos -> dout=0x22, count=2.
- Push 8 values 0x01..0x08 -> full=1, count=8; push 0x99 -> count stays 8, overflow=1; pop -> dout=0x08 (0x99 not stored).
- From empty, pop -> dout unchanged (0 after reset), underflow=1, count=0; err_clr pulse -> underflow=0.
- Stack holds [0x05,0x07]; push 0x0A with pop together -> dout=0x07, count=2; next pop -> dout=0x0A.
- Controller ADD sequence: push 0x03, push 0x04, pop, pop, then push din=0x07 -> dout=0x04 then 0x03 on the cycles after each pop; final count=1 with top=0x07.
- Assert rst=0 asynchronously mid-push burst (count=5) -> count=0, empty=1, dout=0 immediately, without waiting for a clock edge.
